// File: rtl/iic_pkg.sv
// Shared I2C definitions used by the slave receiver and the master side.
//   BYTE_W    : bits per I2C byte
//   ACK_BIT   : bit index of the acknowledge slot (0-based, after BYTE_W data bits)
//   CNT_W     : width of a bit counter that spans 0..ACK_BIT
//   iic_state_e : receiver frame-decode states
package iic_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ACK_BIT = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StChip,
        StReg,
        StData,
        StIgnore
    } iic_state_e;

endpackage

// File: rtl/iics_sync.sv
// Synchronizes scl/sda into the clk domain and detects bus events.
//   clk, rstn          : system clock, synchronous active-low reset
//   scl, sda           : raw I2C pins, asynchronous to clk
//   sda_q              : synchronized sda (current sample)
//   scl_rise, scl_fall : one-cycle scl edge pulses
//   start_det          : sda fell while scl held high
//   stop_det           : sda rose while scl held high
// Events are suppressed until the synchronizer and history flops hold real
// pin samples again after reset, so a reset mid-frame cannot fake a START.
module iics_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl,
    input  logic sda,
    output logic sda_q,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_p;
    logic                   sda_p;
    logic                   scl_q;
    logic [SYNC_STAGES:0]   primed;
    logic                   valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
            primed   <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_p    <= scl_sync[SYNC_STAGES-1];
            sda_p    <= sda_sync[SYNC_STAGES-1];
            primed   <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign scl_q = scl_sync[SYNC_STAGES-1];
    assign sda_q = sda_sync[SYNC_STAGES-1];
    assign valid = primed[SYNC_STAGES];

    // scl stable high on both samples excludes same-cycle scl/sda changes
    assign scl_rise  = valid & ~scl_p & scl_q;
    assign scl_fall  = valid & scl_p & ~scl_q;
    assign start_det = valid & scl_p & scl_q & sda_p & ~sda_q;
    assign stop_det  = valid & scl_p & scl_q & ~sda_p & sda_q;

endmodule

// File: rtl/iics_rx.sv
// I2C write-only slave receiver. Decodes START, chip byte, register byte,
// data bytes..., STOP and emits one wr_valid strobe per data byte.
//   clk, rstn  : system clock, synchronous active-low reset
//   scl, sda   : I2C pins from the master (asynchronous)
//   reg_addr   : register pointer, valid with wr_valid; auto-increments
//   reg_data   : received data byte, valid with wr_valid
//   wr_valid   : one-cycle strobe per accepted data byte
//   busy       : high from START until STOP or abort
//   err        : one-cycle pulse when START/STOP cuts a byte short
//   sda_ack_n  : active-low ACK drive (only when IICS_ACK_EN is defined)
// Build option: define IICS_ACK_EN to generate the ACK driver.
module iics_rx
    import iic_pkg::*;
#(
    parameter logic [7:0]  CHIP_ADDR   = 8'hD0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       wr_valid,
    output logic       busy,
    output logic       err,
    output logic       sda_ack_n
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] CntAck  = CNT_W'(ACK_BIT);

    logic sda_q, scl_rise, scl_fall, start_det, stop_det;

    iics_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .scl      (scl),
        .sda      (sda),
        .sda_q    (sda_q),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    iic_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              pend_q, pend_d;
    logic              match_q, match_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              err_q, err_d;
    logic [BYTE_W-1:0] byte_in;
    logic              in_byte;

    assign byte_in = {shift_q[BYTE_W-2:0], sda_q};
    assign in_byte = (state_q == StChip) || (state_q == StReg) || (state_q == StData);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            pend_q     <= 1'b0;
            match_q    <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            match_q    <= match_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    // A bit is counted on the scl fall that closes it; pend_q marks that its
    // rise was seen. The START/STOP clock pulse has a rise but no fall, so it
    // never counts as a bit and never makes a complete frame look partial.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pend_d     = pend_q;
        match_d    = match_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        wr_valid_d = 1'b0;
        err_d      = 1'b0;

        if (wr_valid_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (start_det || stop_det) begin
            err_d     = in_byte && (bit_cnt_q != '0);
            bit_cnt_d = '0;
            pend_d    = 1'b0;
            state_d   = start_det ? StChip : StIdle;
        end else if (in_byte) begin
            if (scl_rise) begin
                pend_d = 1'b1;
                if (bit_cnt_q < CntAck) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == CntLast) begin
                        case (state_q)
                            StChip: match_d = (byte_in == CHIP_ADDR);
                            StReg:  reg_addr_d = byte_in;
                            StData: begin
                                reg_data_d = byte_in;
                                wr_valid_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            if (scl_fall && pend_q) begin
                pend_d = 1'b0;
                if (bit_cnt_q == CntAck) begin
                    bit_cnt_d = '0;
                    case (state_q)
                        StChip:  state_d = match_q ? StReg : StIgnore;
                        StReg:   state_d = StData;
                        default: ;
                    endcase
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

`ifdef IICS_ACK_EN
    logic ack_q, ack_d;

    // Drive ACK from the fall ending the last data bit to the fall ending the
    // ACK slot; a mismatched chip byte is never acknowledged.
    always_comb begin
        ack_d = ack_q;
        if (start_det || stop_det || !in_byte) begin
            ack_d = 1'b0;
        end else if (scl_fall && pend_q) begin
            if (bit_cnt_q == CntLast) begin
                ack_d = (state_q != StChip) || match_q;
            end else if (bit_cnt_q == CntAck) begin
                ack_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign sda_ack_n = ~ack_q;
`else
    assign sda_ack_n = 1'b1;
`endif

    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;
    assign wr_valid = wr_valid_q;
    assign err      = err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_iics_rx.sv
module tb_iics_rx;

    localparam int Q    = 4;       // clk cycles per quarter scl period
    localparam int NTOK = 12;
    localparam logic [7:0] CHIP = 8'hD0;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic [7:0] reg_addr, reg_data;
    logic       wr_valid, busy, err, sda_ack_n;

    always #5 clk = ~clk;

    iics_rx #(
        .CHIP_ADDR  (CHIP),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .wr_valid (wr_valid),
        .busy     (busy),
        .err      (err),
        .sda_ack_n(sda_ack_n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor: records every write strobe and counts err / long pulses / ACK drive
    logic [15:0] got_q[$];
    int          err_pulses = 0;
    int          long_pulses = 0;
    int          ack_low = 0;
    logic        wv_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_valid) begin
            got_q.push_back({reg_addr, reg_data});
            if (wv_prev) long_pulses <= long_pulses + 1;
        end
        wv_prev <= wr_valid;
        if (err) err_pulses <= err_pulses + 1;
        if (!sda_ack_n) ack_low <= ack_low + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Token encoding: {kind[3:0], nbits[3:0], value[7:0]}
    function automatic logic [15:0] t_s();
        return {4'd1, 12'd0};
    endfunction
    function automatic logic [15:0] t_p();
        return {4'd2, 12'd0};
    endfunction
    function automatic logic [15:0] t_b(input logic [7:0] b);
        return {4'd3, 4'd8, b};
    endfunction
    function automatic logic [15:0] t_h(input int n, input logic [7:0] b);
        return {4'd4, 4'(n), b};
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda = b; wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic send_start();
        sda = 1'b1; wq();
        scl = 1'b1; wq();
        sda = 1'b0; wq();
        scl = 1'b0; wq();
    endtask

    task automatic send_stop();
        sda = 1'b0; wq();
        scl = 1'b1; wq();
        sda = 1'b1; wq();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);  // ACK slot, released by master
    endtask

    task automatic run_tokens(input logic [15:0] toks [NTOK], input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] t;
            t = toks[i];
            case (t[15:12])
                4'd1: send_start();
                4'd2: send_stop();
                4'd3: send_byte(t[7:0]);
                default: for (int k = int'(t[11:8]) - 1; k >= 0; k--) send_bit(t[k]);
            endcase
        end
        repeat (20) @(negedge clk);
    endtask

    // Byte-level reference model of the frame protocol
    logic [15:0] exp_q[$];
    logic [7:0]  m_ptr;
    int          m_err;

    task automatic model(input logic [15:0] toks [NTOK], input int n);
        bit in_frame = 0;
        bit partial  = 0;
        int phase    = 0;  // 0 chip, 1 reg, 2 data, 3 ignored
        exp_q.delete();
        m_err = 0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] t;
            t = toks[i];
            case (t[15:12])
                4'd1, 4'd2: begin
                    if (in_frame && partial) m_err++;
                    in_frame = (t[15:12] == 4'd1);
                    phase = 0;
                    partial = 0;
                end
                4'd3: if (in_frame) begin
                    if (phase == 0) phase = (t[7:0] == CHIP) ? 1 : 3;
                    else if (phase == 1) begin m_ptr = t[7:0]; phase = 2; end
                    else if (phase == 2) begin
                        exp_q.push_back({m_ptr, t[7:0]});
                        m_ptr = m_ptr + 8'd1;
                    end
                end
                default: if (in_frame && phase != 3) partial = 1;
            endcase
        end
    endtask

    typedef struct {
        int          ntok;
        logic [15:0] tok [NTOK];
        int          nexp;
        logic [15:0] exp_w [3];
        int          exp_err;
        logic        exp_busy;
        logic [7:0]  exp_ptr;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic add(input int v, input logic [15:0] t);
        vecs[v].tok[vecs[v].ntok] = t;
        vecs[v].ntok++;
    endtask

    task automatic compare_frame(input string tag, input int bw, input int be, input int bl,
                                 input int nexp, input logic [15:0] ew [$], input int eerr,
                                 input logic ebusy, input logic [7:0] eptr);
        check({tag, " n_writes"}, got_q.size() - bw, nexp);
        for (int i = 0; i < nexp; i++) begin
            if (bw + i < got_q.size()) check({tag, " write"}, int'(got_q[bw + i]), int'(ew[i]));
        end
        check({tag, " err"}, err_pulses - be, eerr);
        check({tag, " busy"}, int'(busy), int'(ebusy));
        check({tag, " reg_addr"}, int'(reg_addr), int'(eptr));
        check({tag, " wr_valid_len"}, long_pulses - bl, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " reg_addr"}, int'(reg_addr), 0);
        check({tag, " reg_data"}, int'(reg_data), 0);
        check({tag, " wr_valid"}, int'(wr_valid), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " err"}, int'(err), 0);
        check({tag, " sda_ack_n"}, int'(sda_ack_n), 1);
    endtask

    initial begin
        int bw, be, bl;
        logic [15:0] ew [$];
        logic [15:0] rt [NTOK];
        int rn;

        for (int v = 0; v < NVEC; v++) begin
            vecs[v].ntok = 0;
            vecs[v].nexp = 0;
            vecs[v].exp_err = 0;
            vecs[v].exp_busy = 1'b0;
        end
        // single write
        add(0, t_s()); add(0, t_b(8'hD0)); add(0, t_b(8'h00)); add(0, t_b(8'h9A)); add(0, t_p());
        vecs[0].nexp = 1; vecs[0].exp_w[0] = 16'h009A; vecs[0].exp_ptr = 8'h01;
        // auto-increment
        add(1, t_s()); add(1, t_b(8'hD0)); add(1, t_b(8'h05)); add(1, t_b(8'h11));
        add(1, t_b(8'h22)); add(1, t_p());
        vecs[1].nexp = 2; vecs[1].exp_w[0] = 16'h0511; vecs[1].exp_w[1] = 16'h0622;
        vecs[1].exp_ptr = 8'h07;
        // pointer wrap, frame left open
        add(2, t_s()); add(2, t_b(8'hD0)); add(2, t_b(8'hFF)); add(2, t_b(8'hAA)); add(2, t_b(8'hBB));
        vecs[2].nexp = 2; vecs[2].exp_w[0] = 16'hFFAA; vecs[2].exp_w[1] = 16'h00BB;
        vecs[2].exp_busy = 1'b1; vecs[2].exp_ptr = 8'h01;
        // other chip address: busy until STOP, no writes
        add(3, t_s()); add(3, t_b(8'hA0)); add(3, t_b(8'h00)); add(3, t_b(8'h55));
        vecs[3].exp_busy = 1'b1; vecs[3].exp_ptr = 8'h01;
        add(4, t_p());
        vecs[4].exp_ptr = 8'h01;
        // partial data byte then STOP
        add(5, t_s()); add(5, t_b(8'hD0)); add(5, t_b(8'h03)); add(5, t_h(4, 8'h0A)); add(5, t_p());
        vecs[5].exp_err = 1; vecs[5].exp_ptr = 8'h03;
        // repeated START after register byte
        add(6, t_s()); add(6, t_b(8'hD0)); add(6, t_b(8'h01)); add(6, t_s()); add(6, t_b(8'hD0));
        add(6, t_b(8'h02)); add(6, t_b(8'h7E)); add(6, t_p());
        vecs[6].nexp = 1; vecs[6].exp_w[0] = 16'h027E; vecs[6].exp_ptr = 8'h03;

        repeat (4) @(negedge clk);
        check_reset_vals("reset");
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            bw = got_q.size(); be = err_pulses; bl = long_pulses;
            run_tokens(vecs[v].tok, vecs[v].ntok);
            ew.delete();
            for (int i = 0; i < vecs[v].nexp; i++) ew.push_back(vecs[v].exp_w[i]);
            compare_frame($sformatf("vec%0d", v), bw, be, bl, vecs[v].nexp, ew,
                          vecs[v].exp_err, vecs[v].exp_busy, vecs[v].exp_ptr);
        end

        // Reset pulse in the middle of the register byte
        bw = got_q.size(); be = err_pulses; bl = long_pulses;
        send_start(); send_byte(8'hD0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_reset_vals("midreset");
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        send_bit(1'b1);
        send_byte(8'h66);
        send_stop();
        repeat (20) @(negedge clk);
        ew.delete();
        compare_frame("midreset_rest", bw, be, bl, 0, ew, 0, 1'b0, 8'h00);
        bw = got_q.size(); be = err_pulses; bl = long_pulses;
        send_start(); send_byte(8'hD0); send_byte(8'h10); send_byte(8'h3C); send_stop();
        repeat (20) @(negedge clk);
        ew.push_back(16'h103C);
        compare_frame("after_reset", bw, be, bl, 1, ew, 0, 1'b0, 8'h11);

        // Randomized frames against the reference model
        m_ptr = 8'h11;
        for (int f = 0; f < 30; f++) begin
            rn = 0;
            rt[rn++] = t_s();
            rt[rn++] = t_b(($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : CHIP);
            rt[rn++] = t_b(8'($urandom));
            for (int d = $urandom_range(0, 3); d > 0; d--) rt[rn++] = t_b(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                rt[rn++] = t_s();
                rt[rn++] = t_b(CHIP);
                rt[rn++] = t_b(8'($urandom));
                rt[rn++] = t_b(8'($urandom));
            end
            if ($urandom_range(0, 3) == 0) rt[rn++] = t_h($urandom_range(1, 7), 8'($urandom));
            rt[rn++] = t_p();
            model(rt, rn);
            bw = got_q.size(); be = err_pulses; bl = long_pulses;
            run_tokens(rt, rn);
            compare_frame($sformatf("rand%0d", f), bw, be, bl, exp_q.size(), exp_q, m_err,
                          1'b0, m_ptr);
        end

        check("ack_n_never_low", ack_low, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
